module_decodificador_secded: RTL and testbench



---
 rtl/secded_pkg.sv | 43 ++++
 rtl/module_sindrome_secded.sv | 27 ++
 rtl/module_decodificador_secded.sv | 153 +++++++++++++++
 tb/tb_module_decodificador_secded.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED (extended Hamming) decoder.
// Holds the result-status encoding and the constant functions that size
// the codeword and locate data bits inside it.
package secded_pkg;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,  // clean word
        ST_CORR = 2'b01,  // single-bit error corrected
        ST_DBL  = 2'b10,  // double-bit error detected
        ST_INV  = 2'b11   // odd parity but syndrome points outside the word
    } status_t;

    // Number of Hamming check bits R: smallest R with 2^R >= data_w + R + 1.
    function automatic int secded_calc_r(input int data_w);
        int r;
        r = 1;
        for (int k = 0; k < 8; k++) begin
            if ((1 << r) < (data_w + r + 1)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Hamming position (1-based) holding data bit j. Data bits fill the
    // non-power-of-two positions in ascending order.
    function automatic int secded_data_pos(input int j);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int i = 1; i < 128; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == j) begin
                    res = i;
                end
                cnt = cnt + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/module_sindrome_secded.sv
// Purpose: combinational syndrome and overall-parity generator for a SECDED codeword.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
// Ports: codeword (CW bits, bit 0 = overall parity) -> sindrome (R bits), parity (1 bit).
module module_sindrome_secded #(
    parameter int CW = 13,
    parameter int R  = 4
) (
    input  logic [CW-1:0] codeword,
    output logic [R-1:0]  sindrome,
    output logic          parity
);

    // Syndrome is the XOR of the Hamming indices of every set bit; bit 0
    // (overall parity) has index 0 and so never contributes.
    always_comb begin
        sindrome = '0;
        for (int i = 1; i < CW; i++) begin
            if (codeword[i]) begin
                sindrome = sindrome ^ R'(i);
            end
        end
    end

    assign parity = ^codeword;

endmodule

// File: rtl/module_decodificador_secded.sv
// Purpose: two-stage SECDED decoder with valid/ready handshakes and optional error counters.
// Latency: 2 cycles from input handshake to out_valid; one word per cycle while out_ready=1.
// Backpressure: out_ready low stalls both stages; in_ready drops once stage 1 is full and cannot advance.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_codeword; out_valid/out_ready,
//        out_data, out_status, out_sindrome, out_err_pos; clr_cnt, cnt_corr, cnt_dbl.
// Build option: define SECDED_STATS_EN to implement the cnt_corr/cnt_dbl counters;
//               otherwise they read 0 and clr_cnt is ignored.
module module_decodificador_secded
    import secded_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int R     = secded_calc_r(DATA_W),
    localparam int CW    = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    output logic [R-1:0]      out_sindrome,
    output logic [R-1:0]      out_err_pos,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_dbl
);

    localparam logic [R-1:0] MAX_POS = R'(CW - 1);

    // ---------------- stage 1: syndrome / parity ----------------
    logic [R-1:0]  sind_c;
    logic          par_c;
    logic          s1_valid;
    logic [CW-1:0] s1_cw;
    logic [R-1:0]  s1_sind;
    logic          s1_par;
    logic          advance;

    module_sindrome_secded #(
        .CW (CW),
        .R  (R)
    ) u_sindrome (
        .codeword (in_codeword),
        .sindrome (sind_c),
        .parity   (par_c)
    );

    // Both stages move together whenever the output register is free or draining.
    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_sind  <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw   <= in_codeword;
                s1_sind <= sind_c;
                s1_par  <= par_c;
            end
        end
    end

    // ---------------- correction / classification ----------------
    status_t           st_c;
    logic [R-1:0]      pos_c;
    logic [CW-1:0]     cw_fix;
    logic [DATA_W-1:0] data_raw;
    logic [DATA_W-1:0] data_fix;

    always_comb begin
        st_c   = ST_OK;
        pos_c  = '0;
        cw_fix = s1_cw;
        if (!s1_par) begin
            st_c = (s1_sind == '0) ? ST_OK : ST_DBL;
        end else if (s1_sind <= MAX_POS) begin
            // Odd parity with an in-range syndrome: single error at that
            // position (syndrome 0 means p0 itself flipped).
            st_c  = ST_CORR;
            pos_c = s1_sind;
            for (int i = 0; i < CW; i++) begin
                if (R'(i) == s1_sind) begin
                    cw_fix[i] = ~s1_cw[i];
                end
            end
        end else begin
            st_c = ST_INV;
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_extract
        assign data_raw[j] = s1_cw[secded_data_pos(j)];
        assign data_fix[j] = cw_fix[secded_data_pos(j)];
    end

    // ---------------- stage 2: output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_status   <= 2'b00;
            out_sindrome <= '0;
            out_err_pos  <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= (st_c == ST_CORR) ? data_fix : data_raw;
                out_status   <= st_c;
                out_sindrome <= s1_sind;
                out_err_pos  <= pos_c;
            end
        end
    end

    // ---------------- error statistics ----------------
`ifdef SECDED_STATS_EN
    logic out_hs;
    assign out_hs = out_valid && out_ready;

    // Saturating counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr <= '0;
            cnt_dbl  <= '0;
        end else if (clr_cnt) begin
            cnt_corr <= '0;
            cnt_dbl  <= '0;
        end else if (out_hs) begin
            if (out_status == ST_CORR && cnt_corr != '1) begin
                cnt_corr <= cnt_corr + 1'b1;
            end
            if (out_status[1] && cnt_dbl != '1) begin
                cnt_dbl <= cnt_dbl + 1'b1;
            end
        end
    end
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign cnt_corr       = '0;
    assign cnt_dbl        = '0;
`endif

endmodule

// File: tb/tb_module_decodificador_secded.sv
module tb_module_decodificador_secded;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int R      = 4;
    localparam int CW     = 13;
`ifdef SECDED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    // encode(0xA5): data at positions 3,5,6,7,9,10,11,12 -> set 3,6,10,12;
    // their index XOR is 3, so p1=p2=1; six ones total -> p0=0.
    localparam logic [CW-1:0] CW_A5 = 13'h144E;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CW-1:0]     in_codeword = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [R-1:0]      out_sindrome;
    logic [R-1:0]      out_err_pos;
    logic              clr_cnt = 1'b0;
    logic [CNT_W-1:0]  cnt_corr;
    logic [CNT_W-1:0]  cnt_dbl;

    module_decodificador_secded #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_codeword  (in_codeword),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_status   (out_status),
        .out_sindrome (out_sindrome),
        .out_err_pos  (out_err_pos),
        .clr_cnt      (clr_cnt),
        .cnt_corr     (cnt_corr),
        .cnt_dbl      (cnt_dbl)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: data into non-power-of-two positions, check bits
    // cancel the data syndrome, p0 makes total parity even.
    function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW-1:0] c;
        logic [R-1:0]  s;
        int k;
        c = '0;
        k = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k++;
            end
        end
        s = '0;
        for (int i = 1; i < CW; i++) begin
            if (c[i]) s = s ^ R'(i);
        end
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    // Send one word into an empty pipeline and capture its result.
    // Returns on the negedge after the output handshake.
    task automatic xfer(input logic [CW-1:0] cw, input logic clr_at_out,
                        output logic [DATA_W-1:0] d, output logic [1:0] st,
                        output logic [R-1:0] sy, output logic [R-1:0] ep,
                        output int lat);
        int guard;
        @(negedge clk);
        in_codeword = cw;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d  = out_data;
        st = out_status;
        sy = out_sindrome;
        ep = out_err_pos;
        clr_cnt = clr_at_out;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    logic [DATA_W-1:0] d;
    logic [1:0]        st;
    logic [R-1:0]      sy;
    logic [R-1:0]      ep;
    int                lat;

    logic [CW-1:0]     bw[4];
    logic [DATA_W-1:0] bd[4];
    logic [DATA_W-1:0] rx[4];
    int                idx;
    int                got;
    int                guard;
    int                stale;
    logic              rdy;
    logic              ov;
    logic [DATA_W-1:0] od;
    int                posl[5];

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_status", 32'(out_status), 0);
        chk("rst_sindrome", 32'(out_sindrome), 0);
        chk("rst_err_pos", 32'(out_err_pos), 0);
        chk("rst_cnt_corr", 32'(cnt_corr), 0);
        chk("rst_cnt_dbl", 32'(cnt_dbl), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);

        // ---------------- clean word ----------------
        xfer(CW_A5, 1'b0, d, st, sy, ep, lat);
        chk("clean_latency", lat, 2);
        chk("clean_data", 32'(d), 32'hA5);
        chk("clean_status", 32'(st), 0);
        chk("clean_sindrome", 32'(sy), 0);
        chk("clean_cnt_corr", 32'(cnt_corr), 0);

        // ---------------- single error, position 5 ----------------
        xfer(CW_A5 ^ 13'h0020, 1'b0, d, st, sy, ep, lat);
        chk("pos5_data", 32'(d), 32'hA5);
        chk("pos5_status", 32'(st), 1);
        chk("pos5_err_pos", 32'(ep), 5);
        chk("pos5_sindrome", 32'(sy), 5);
        chk("pos5_cnt_corr", 32'(cnt_corr), STATS ? 1 : 0);

        // ---------------- p0 only flipped ----------------
        xfer(CW_A5 ^ 13'h0001, 1'b0, d, st, sy, ep, lat);
        chk("p0_data", 32'(d), 32'hA5);
        chk("p0_status", 32'(st), 1);
        chk("p0_err_pos", 32'(ep), 0);
        chk("p0_cnt_corr", 32'(cnt_corr), STATS ? 2 : 0);

        // ---------------- double error, positions 3 and 6 ----------------
        // Syndrome 3^6=5, even parity; data bits d0,d2 stay flipped -> 0xA0.
        xfer(CW_A5 ^ 13'h0048, 1'b0, d, st, sy, ep, lat);
        chk("dbl_status", 32'(st), 2);
        chk("dbl_sindrome", 32'(sy), 5);
        chk("dbl_data", 32'(d), 32'hA0);
        chk("dbl_cnt_dbl", 32'(cnt_dbl), STATS ? 1 : 0);

        // ---------------- invalid syndrome, positions 1,4,8 ----------------
        xfer(CW_A5 ^ 13'h0112, 1'b0, d, st, sy, ep, lat);
        chk("inv_status", 32'(st), 3);
        chk("inv_sindrome", 32'(sy), 13);
        chk("inv_data", 32'(d), 32'hA5);
        chk("inv_cnt_dbl", 32'(cnt_dbl), STATS ? 2 : 0);
        chk("inv_cnt_corr", 32'(cnt_corr), STATS ? 2 : 0);

        // ---------------- idle clear ----------------
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("clr_cnt_corr", 32'(cnt_corr), 0);
        chk("clr_cnt_dbl", 32'(cnt_dbl), 0);

        // ---------------- saturation: 5 single errors on a 2-bit counter ----------------
        posl = '{5, 7, 9, 11, 0};
        for (int i = 0; i < 5; i++) begin
            xfer(CW_A5 ^ (13'd1 << posl[i]), 1'b0, d, st, sy, ep, lat);
            chk("sat_data", 32'(d), 32'hA5);
        end
        chk("sat_cnt_corr", 32'(cnt_corr), STATS ? 3 : 0);

        // ---------------- clear coincident with an increment ----------------
        xfer(CW_A5 ^ 13'h0200, 1'b1, d, st, sy, ep, lat);
        chk("clrinc_status", 32'(st), 1);
        chk("clrinc_cnt_corr", 32'(cnt_corr), 0);

        // ---------------- backpressure ----------------
        bd = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) bw[i] = encode(bd[i]);
        bw[2] = bw[2] ^ 13'h0080;  // single error rides through the stall
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready   = 1'b0;
            in_valid    = 1'b1;
            in_codeword = bw[idx];
            #1;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) idx++;
        end
        @(negedge clk);
        #1;
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_hold_data", 32'(out_data), 32'h11);
        got = 0;
        guard = 0;
        while (got < 4 && guard < 30) begin
            out_ready = 1'b1;
            if (idx < 4) begin
                in_valid    = 1'b1;
                in_codeword = bw[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            rdy = in_ready && in_valid;
            ov  = out_valid;
            od  = out_data;
            @(posedge clk);
            if (rdy) idx++;
            if (ov) begin
                rx[got] = od;
                got++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("bp_count", got, 4);
        for (int i = 0; i < 4; i++) chk("bp_order", 32'(rx[i]), 32'(bd[i]));
        chk("bp_cnt_corr", 32'(cnt_corr), STATS ? 1 : 0);

        // ---------------- reset with two words in flight ----------------
        @(negedge clk);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_codeword = encode(8'h5A);
        @(negedge clk);
        in_codeword = encode(8'h3C) ^ 13'h0004;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_cnt_corr", 32'(cnt_corr), 0);
        chk("mid_rst_cnt_dbl", 32'(cnt_dbl), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("mid_no_stale", stale, 0);
        chk("mid_in_ready", 32'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
